// File: rtl/snake_pkg.sv
// Shared constants for the snake game blocks: FSM state encoding and bus widths.
package snake_pkg;

   localparam int unsigned SCORE_W = 4;
   localparam int unsigned LEVEL_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2,
      ST_WIN  = 2'd3
   } state_t;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: one-cycle registered delay of the input, ANDed with
// the inverted delayed copy. Usable for apple-eaten and button inputs alike.
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);

   logic in_d;

   // Delay register, updated every cycle regardless of game state
   always_ff @(posedge clk) begin
      if (!rst_n) in_d <= 1'b0;
      else        in_d <= in;
   end

   assign rise = in & ~in_d;

endmodule

// File: rtl/score_counter.sv
// Snake game score tracker: game-state FSM, apple counter, speed level and
// optional best-score register (enabled with macro SCORE_HISCORE_EN).
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for start
// PLAY    | game running, apples counted
// OVER    | snake crashed, score frozen until start
// WIN     | SCORE_MAX reached, score frozen until start
module score_counter
   import snake_pkg::*;
#(
   parameter int unsigned SCORE_MAX  = 15,
   parameter int unsigned LEVEL_STEP = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               eat,
   input  logic               crash,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] hiscore,
   output logic [LEVEL_W-1:0] level,
   output logic               playing,
   output logic               game_over,
   output logic               win
);

   localparam logic [SCORE_W-1:0] MAX_V  = SCORE_W'(SCORE_MAX);
   localparam logic [SCORE_W-1:0] STEP_V = SCORE_W'(LEVEL_STEP);
   localparam logic [SCORE_W-1:0] LVL_TOP = SCORE_W'(3);

   state_t             state, state_nxt;
   logic               eat_rise;
   logic               enter_play;
   logic [SCORE_W-1:0] score_nxt;
   logic [SCORE_W-1:0] level_quot;
   logic [LEVEL_W-1:0] level_nxt;
   logic               playing_nxt, game_over_nxt, win_nxt;

   edge_rise u_eat_rise (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (eat),
      .rise (eat_rise)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; crash takes precedence over a winning apple
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_PLAY;
         ST_PLAY: begin
            if (crash)
               state_nxt = ST_OVER;
            else if (eat_rise && ((score + SCORE_W'(1)) == MAX_V))
               state_nxt = ST_WIN;
         end
         ST_OVER: if (start) state_nxt = ST_PLAY;
         ST_WIN:  if (start) state_nxt = ST_PLAY;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next score and level; level follows the next score so both update together
   always_comb begin
      enter_play = (state != ST_PLAY) && (state_nxt == ST_PLAY);
      score_nxt  = score;
      if (enter_play)
         score_nxt = '0;
      else if ((state == ST_PLAY) && eat_rise && !crash && (score < MAX_V))
         score_nxt = score + SCORE_W'(1);
      level_quot = score_nxt / STEP_V;
      level_nxt  = (level_quot > LVL_TOP) ? LEVEL_W'(3) : level_quot[LEVEL_W-1:0];
   end

   // Output decode from the next state so the flags register alongside it
   always_comb begin
      playing_nxt   = (state_nxt == ST_PLAY);
      game_over_nxt = (state_nxt == ST_OVER);
      win_nxt       = (state_nxt == ST_WIN);
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         score     <= '0;
         level     <= '0;
         playing   <= 1'b0;
         game_over <= 1'b0;
         win       <= 1'b0;
      end else begin
         score     <= score_nxt;
         level     <= level_nxt;
         playing   <= playing_nxt;
         game_over <= game_over_nxt;
         win       <= win_nxt;
      end
   end

`ifdef SCORE_HISCORE_EN
   logic               enter_end;
   logic [SCORE_W-1:0] hiscore_q;

   // Best score captured on the edge a game ends; survives restarts
   always_ff @(posedge clk) begin
      if (!rst_n)
         hiscore_q <= '0;
      else if (enter_end && (score_nxt > hiscore_q))
         hiscore_q <= score_nxt;
   end

   assign enter_end = (state == ST_PLAY) &&
                      ((state_nxt == ST_OVER) || (state_nxt == ST_WIN));
   assign hiscore   = hiscore_q;
`else
   assign hiscore = '0;
`endif

endmodule
